data_memory: RTL and testbench
==============================

# data_memory

Byte-wide data memory lane used by the execute stage. Four instances sit side by side, one per byte of a 32-bit word, sharing one word address, to form the processor's data memory. Reads are combinational so that load results are available in the same cycle as the address. Writes are synchronous, one byte per lane, which supports byte, halfword and word stores through per-lane write enables.

## Interface

Parameters:
- `ADDR_BITS`, default 10: number of word-address bits actually decoded; memory depth is 2^ADDR_BITS entries.
- `DATA_BITS`, default 8: width of one entry; fixed at 8 for processor use.

Ports:
- `clk`  input  1  single clock; all state changes on rising edge. One clock only.
- `rst_n`  input  1  reset, asynchronous, active-low; clears the entire array.
- `wordaddr`  input  32  word address, already divided by 4 by the caller.
- `writeData`  input  8  byte to store.
- `writeEnable`  input  1  active-high write strobe for this lane.
- `readData`  output  8  byte stored at the addressed entry.

## Operation

- Storage: array of 2^ADDR_BITS entries, each DATA_BITS wide, implemented as registers so that it can be reset.
- Address decode: only `wordaddr[ADDR_BITS-1:0]` is used. Upper bits are ignored, so addresses wrap modulo depth; there is no out-of-range error.
- Read: `readData = mem[wordaddr[ADDR_BITS-1:0]]`, purely combinational. There is no read enable, and a read has no side effects.
- Write: on a rising `clk` edge with `rst_n`=1 and `writeEnable`=1, `mem[index] <= writeData`. When `writeEnable`=0, the array is unchanged.
- Reset: while `rst_n`=0, every entry is forced to 0 immediately, without waiting for a clock edge. `readData` therefore reads 0 at any address. Writes are ignored while reset is asserted.
- X handling: `writeEnable` is treated as 0 unless it is exactly 1.

## Timing

- Read latency: 0 cycles, combinational from `wordaddr` and array contents to `readData`.
- Write latency: data is visible on `readData` just after the rising edge that captures it.
- Read during write to the same address in the same cycle: `readData` shows the old value before the edge and the new value after it. There is no bypass of `writeData`.
- Back-to-back writes to the same address on consecutive cycles: the last write wins, one per edge.
- Reset asserted mid-operation: the array and `readData` go to 0 asynchronously. A write on an edge coincident with reset assertion is discarded.
- Reset release: the first write takes effect on the first rising edge with `rst_n`=1.
- Reset value of outputs: `readData` = 8'h00.

## Test plan

- Reset: hold `rst_n`=0, sweep `wordaddr` 0..3 -> `readData`=8'h00 at every address. Pulse `writeEnable`=1 with `writeData`=8'hAA during reset -> `readData` still 8'h00 after release.
- Write/read: write 8'h5C at address 7 and 8'hA3 at address 8 on consecutive edges. Then set `wordaddr`=7 -> 8'h5C with no clock edge needed; set 8 -> 8'hA3.
- Write disable: at address 7, apply `writeData`=8'hFF with `writeEnable`=0 over several edges -> `readData` stays 8'h5C.
- Same-cycle read/write: `wordaddr`=7, `writeData`=8'h11, `writeEnable`=1 -> `readData`=8'h5C before the edge, 8'h11 after it.
- Wrap-around (ADDR_BITS=10): write 8'h77 at `wordaddr`=32'h0000_0403 -> reading `wordaddr`=3 returns 8'h77.
- Four-lane word: four instances with enables 4'b1111 store 32'hDEADBEEF at address 2. Then enables 4'b0001 store 8'h00 -> the concatenated read is 32'hDEADBE00.

Source files
------------

// File: rtl/data_memory.sv
// Byte-wide data memory lane with combinational read and registered write.
// Four lanes sharing one word address form the 32-bit data memory.
module data_memory #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          wordaddr,
  input  logic [DATA_BITS-1:0] writeData,
  input  logic                 writeEnable,
  output logic [DATA_BITS-1:0] readData
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] index;
  logic                 unused_hi;

  // Upper address bits are dropped so addresses wrap modulo depth.
  assign index     = wordaddr[ADDR_BITS-1:0];
  assign unused_hi = ^wordaddr[31:ADDR_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEnable == 1'b1) begin
      mem[index] <= writeData;
    end
  end

  assign readData = mem[index];

endmodule

// File: tb/tb_data_memory.sv
// Four-lane word memory exercised with directed and random traffic.
// A monitor compares each cycle's read against a queued expectation.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wordaddr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    data_memory #(.ADDR_BITS(10), .DATA_BITS(8)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .wordaddr   (wordaddr),
      .writeData  (wdata[8*l +: 8]),
      .writeEnable(we[l]),
      .readData   (rdata[8*l +: 8])
    );
  end

  typedef struct {
    int          cyc;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model [4][1024];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'(a % 32'd1024);
    return {model[3][idx], model[2][idx], model[1][idx], model[0][idx]};
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 1024; i++)
        model[l][i] = 8'h00;
  endfunction

  // Drive one cycle: expect the pre-edge read, then commit the write.
  task automatic step(input logic [31:0] a, input logic [3:0] e,
                      input logic [31:0] d, input string nm);
    int idx;
    wordaddr = a;
    we       = e;
    wdata    = d;
    q.push_back('{cyc, model_read(a), nm});
    @(posedge clk);
    idx = int'(a % 32'd1024);
    if (rst_n === 1'b1)
      for (int l = 0; l < 4; l++)
        if (e[l]) model[l][idx] = d[8*l +: 8];
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (x.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check missed, cycle %0d required %0d",
                 x.name, cyc, x.cyc);
      end else if (rdata !== x.exp) begin
        errors++;
        $display("FAIL %s: readData=%h required %h", x.name, rdata, x.exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    rst_n    = 1'b1;
    wordaddr = '0;
    wdata    = '0;
    we       = '0;
    #2;
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++)
      step(i, 4'h0, 32'h0, "reset_sweep");
    step(0, 4'hF, 32'hAAAA_AAAA, "reset_write_ignored");
    rst_n = 1'b1;
    step(0, 4'h0, 32'h0, "after_release");

    step(7, 4'h1, 32'h0000_005C, "write_a7");
    step(8, 4'h1, 32'h0000_00A3, "write_a8");
    step(7, 4'h0, 32'h0, "read_a7");
    step(8, 4'h0, 32'h0, "read_a8");
    for (int i = 0; i < 3; i++)
      step(7, 4'h0, 32'hFFFF_FFFF, "write_disabled");
    step(7, 4'h1, 32'h0000_0011, "rw_same_cycle_old");
    step(7, 4'h0, 32'h0, "rw_same_cycle_new");
    step(7, 4'h1, 32'h0000_0022, "b2b_first");
    step(7, 4'h1, 32'h0000_0033, "b2b_second");
    step(7, 4'h0, 32'h0, "b2b_last_wins");

    step(32'h0000_0403, 4'h1, 32'h0000_0077, "wrap_write");
    step(3, 4'h0, 32'h0, "wrap_read");

    step(2, 4'hF, 32'hDEAD_BEEF, "word_write");
    step(2, 4'h1, 32'h0000_0000, "word_read_full");
    step(2, 4'h0, 32'h0, "word_byte_store");

    for (int i = 0; i < 300; i++) begin
      a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
      step(a, 4'($urandom()), $urandom(), "random");
    end

    // Reset asserted between edges must clear reads with no clock edge.
    rst_n = 1'b0;
    model_clear();
    step(2, 4'hF, 32'h1234_5678, "async_reset_clear");
    step(7, 4'h0, 32'h0, "async_reset_hold");
    rst_n = 1'b1;
    step(2, 4'hF, 32'hCAFE_F00D, "first_write_after_release");
    step(2, 4'h0, 32'h0, "read_after_release_write");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
